// File: rtl/tx_resp_arbiter.sv
// tx_resp_arbiter
// Shares the single TX FIFO write port between two response sources:
// register-file read data (one byte) and ALU results (two bytes, LSB first).
// Each source owns a one-entry holding buffer. A round-robin FSM drains the
// buffers one byte per cycle and stalls while the FIFO reports full.

module tx_resp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RF_DATA,
    input  logic                  RF_VLD,
    input  logic [ALU_WIDTH-1:0]  ALU_DATA,
    input  logic                  ALU_VLD,
    input  logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  WR_INC,
    output logic                  RF_PEND,
    output logic                  ALU_PEND,
    output logic                  DROP,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_RF     = 2'd1,
        SEND_ALU_LO = 2'd2,
        SEND_ALU_HI = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [DATA_WIDTH-1:0] rf_buf;
    logic [ALU_WIDTH-1:0]  alu_buf;
    logic                  rf_pend;
    logic                  alu_pend;
    logic                  drop_q;

    // Set when the most recent contested grant went to the ALU. It only
    // moves when both sources compete, so an uncontested grant does not
    // disturb the fairness order between them.
    logic                  last_alu;

    logic                  write_now;
    logic                  rf_final;
    logic                  alu_final;
    logic                  rf_take;
    logic                  alu_take;
    logic                  rf_drop;
    logic                  alu_drop;
    logic                  tie;
    logic                  grant_alu;

    // Write strobe and final-byte detection derived from the registered state.
    always_comb begin
        write_now = (state_q != IDLE) && !FIFO_FULL;
        rf_final  = write_now && (state_q == SEND_RF);
        alu_final = write_now && (state_q == SEND_ALU_HI);
        rf_take   = RF_VLD  && (!rf_pend  || rf_final);
        alu_take  = ALU_VLD && (!alu_pend || alu_final);
        rf_drop   = RF_VLD  && rf_pend  && !rf_final;
        alu_drop  = ALU_VLD && alu_pend && !alu_final;
        tie       = (state_q == IDLE) && rf_pend && alu_pend;
        grant_alu = !last_alu;
    end

    // Next-state logic: arbitrate in IDLE, advance only on cycles that write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rf_pend && alu_pend) begin
                    state_d = grant_alu ? SEND_ALU_LO : SEND_RF;
                end else if (rf_pend) begin
                    state_d = SEND_RF;
                end else if (alu_pend) begin
                    state_d = SEND_ALU_LO;
                end
            end
            SEND_RF: begin
                if (write_now) begin
                    state_d = IDLE;
                end
            end
            SEND_ALU_LO: begin
                if (write_now) begin
                    state_d = SEND_ALU_HI;
                end
            end
            SEND_ALU_HI: begin
                if (write_now) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fairness flag: reset to ALU so the register file wins the first tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_alu <= 1'b1;
        end else if (tie) begin
            last_alu <= grant_alu;
        end
    end

    // Register-file holding buffer; a capture on the final write keeps it full.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rf_buf  <= '0;
            rf_pend <= 1'b0;
        end else if (rf_take) begin
            rf_buf  <= RF_DATA;
            rf_pend <= 1'b1;
        end else if (rf_final) begin
            rf_pend <= 1'b0;
        end
    end

    // ALU holding buffer; it clears only after the high byte is written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_buf  <= '0;
            alu_pend <= 1'b0;
        end else if (alu_take) begin
            alu_buf  <= ALU_DATA;
            alu_pend <= 1'b1;
        end else if (alu_final) begin
            alu_pend <= 1'b0;
        end
    end

    // One-cycle pulse flagging a valid that arrived while its buffer was full.
    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= rf_drop || alu_drop;
        end
    end

    // Byte selection for the FIFO. The buffers cannot change mid-state, so
    // the byte is held across FIFO_FULL stalls.
    always_comb begin
        WR_DATA = '0;
        case (state_q)
            SEND_RF:     WR_DATA = rf_buf;
            SEND_ALU_LO: WR_DATA = alu_buf[DATA_WIDTH-1:0];
            SEND_ALU_HI: WR_DATA = alu_buf[ALU_WIDTH-1:DATA_WIDTH];
            default:     WR_DATA = '0;
        endcase
    end

    assign WR_INC   = write_now;
    assign RF_PEND  = rf_pend;
    assign ALU_PEND = alu_pend;
    assign DROP     = drop_q;
    assign BUSY     = (state_q != IDLE);

endmodule
